// File: rtl/mor1kx_pcu_sampler.sv
// SPR bus initiator that snapshots the PCCR performance counters as a burst,
// on a trigger pulse or a periodic tick, and streams them out on a valid/ready port.
module mor1kx_pcu_sampler #(
  parameter int          OPTION_PERFCOUNTERS_NUM = 7,
  parameter logic [15:0] PCCR_BASE               = 16'h3800,
  parameter int          PERIOD_WIDTH            = 16,
  parameter int          ACK_TIMEOUT             = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    trigger_i,
  input  logic [PERIOD_WIDTH-1:0] cfg_period_i,
  input  logic                    err_clr_i,
  output logic                    spr_access_o,
  output logic                    spr_re_o,
  output logic                    spr_we_o,
  output logic [15:0]             spr_addr_o,
  input  logic                    spr_bus_ack_i,
  input  logic [31:0]             spr_dat_i,
  output logic                    smp_valid_o,
  input  logic                    smp_ready_i,
  output logic [31:0]             smp_data_o,
  output logic [2:0]              smp_idx_o,
  output logic                    smp_last_o,
  output logic [7:0]              smp_seq_o,
  output logic                    busy_o,
  output logic [7:0]              drop_cnt_o,
  output logic                    timeout_err_o
);

  localparam int WW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, OUT} state_t;

  state_t                  state, state_nxt;
  logic [2:0]              idx;
  logic [PERIOD_WIDTH-1:0] timer;
  logic [WW-1:0]           wait_cnt;
  logic [7:0]              seq, drop_cnt;
  logic [31:0]             data_q;
  logic                    err_q;

  logic tick, start, last, ack_to, accept;

  // >= rather than == so a period shrunk below the running timer fires at once
  assign tick   = (cfg_period_i != '0) && (timer >= cfg_period_i - PERIOD_WIDTH'(1));
  assign start  = trigger_i | tick;
  assign last   = (idx == 3'(OPTION_PERFCOUNTERS_NUM));
  assign ack_to = (state == REQ) && !spr_bus_ack_i && (wait_cnt == WW'(ACK_TIMEOUT - 1));
  assign accept = (state == OUT) && smp_ready_i;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = REQ;
      REQ: begin
        if (spr_bus_ack_i) state_nxt = OUT;
        else if (ack_to)   state_nxt = IDLE;
      end
      OUT: if (accept) state_nxt = last ? IDLE : REQ;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      timer    <= '0;
      wait_cnt <= '0;
      seq      <= '0;
      drop_cnt <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;

      if (cfg_period_i == '0 || tick) timer <= '0;
      else                            timer <= timer + PERIOD_WIDTH'(1);

      // trigger and tick together are one start, so at most one drop
      if (state != IDLE && start && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;

      if (state == REQ && !spr_bus_ack_i) wait_cnt <= wait_cnt + WW'(1);
      else                                wait_cnt <= '0;

      if (state == IDLE && start) idx <= '0;
      if (state == REQ && spr_bus_ack_i) data_q <= spr_dat_i;
      if (accept && !last) idx <= idx + 3'd1;
      if ((accept && last) || ack_to) seq <= seq + 8'd1;

      if (ack_to)         err_q <= 1'b1;
      else if (err_clr_i) err_q <= 1'b0;
    end
  end

  assign spr_access_o  = (state == REQ);
  assign spr_re_o      = spr_access_o;
  assign spr_we_o      = 1'b0;
  assign spr_addr_o    = PCCR_BASE + {13'd0, idx};
  assign smp_valid_o   = (state == OUT);
  assign smp_data_o    = data_q;
  assign smp_idx_o     = idx;
  assign smp_last_o    = (state == OUT) && last;
  assign smp_seq_o     = seq;
  assign busy_o        = (state != IDLE);
  assign drop_cnt_o    = drop_cnt;
  assign timeout_err_o = err_q;

endmodule

// File: tb/tb_mor1kx_pcu_sampler.sv
// Directed bench for mor1kx_pcu_sampler; a small SPR responder returns 0x100+i for PCCRi.
module tb_mor1kx_pcu_sampler;
  logic        clk = 0, rst = 1, trigger_i = 0, err_clr_i = 0;
  logic [15:0] cfg_period_i = 0;
  logic        spr_access_o, spr_re_o, spr_we_o, spr_bus_ack_i;
  logic [15:0] spr_addr_o;
  logic [31:0] spr_dat_i, smp_data_o;
  logic        smp_valid_o, smp_ready_i = 1, smp_last_o, busy_o, timeout_err_o;
  logic [2:0]  smp_idx_o;
  logic [7:0]  smp_seq_o, drop_cnt_o;
  logic        ack_en = 1;
  int          total = 0, bad = 0, reads = 0;

  always #5 clk = ~clk;

  assign spr_bus_ack_i = ack_en & spr_access_o;
  assign spr_dat_i     = 32'h100 + {16'd0, spr_addr_o - 16'h3800};

  always @(posedge clk) if (spr_access_o && spr_bus_ack_i) reads <= reads + 1;

  mor1kx_pcu_sampler dut (
    .clk(clk), .rst(rst), .trigger_i(trigger_i), .cfg_period_i(cfg_period_i),
    .err_clr_i(err_clr_i), .spr_access_o(spr_access_o), .spr_re_o(spr_re_o),
    .spr_we_o(spr_we_o), .spr_addr_o(spr_addr_o), .spr_bus_ack_i(spr_bus_ack_i),
    .spr_dat_i(spr_dat_i), .smp_valid_o(smp_valid_o), .smp_ready_i(smp_ready_i),
    .smp_data_o(smp_data_o), .smp_idx_o(smp_idx_o), .smp_last_o(smp_last_o),
    .smp_seq_o(smp_seq_o), .busy_o(busy_o), .drop_cnt_o(drop_cnt_o),
    .timeout_err_o(timeout_err_o)
  );

  task automatic pulse_trigger();
    trigger_i = 1; @(negedge clk); trigger_i = 0;
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    while (busy_o && c < 200) begin @(negedge clk); c++; end
    total++;
    if (busy_o) begin bad++; $display("FAIL %s: busy_o still %b after %0d cycles, required 0", name, busy_o, c); end
  endtask

  task automatic test_reset();
    rst = 1; repeat (3) @(negedge clk);
    total++;
    if ({spr_access_o, spr_re_o, spr_we_o, smp_valid_o, smp_last_o, busy_o, timeout_err_o} !== 7'd0 ||
        smp_data_o !== 0 || smp_idx_o !== 0 || smp_seq_o !== 0 || drop_cnt_o !== 0 || spr_addr_o !== 16'h3800) begin
      bad++; $display("FAIL reset: acc=%b vld=%b busy=%b data=%h idx=%0d seq=%0d drop=%0d addr=%h, required all 0 addr=3800",
                      spr_access_o, smp_valid_o, busy_o, smp_data_o, smp_idx_o, smp_seq_o, drop_cnt_o, spr_addr_o);
    end
    rst = 0; @(negedge clk);
  endtask

  task automatic test_burst();
    int n = 0, c = 0, r0;
    r0 = reads;
    pulse_trigger();
    total++;
    if (spr_access_o !== 1 || spr_re_o !== 1 || spr_addr_o !== 16'h3800 || smp_valid_o !== 0) begin
      bad++; $display("FAIL latency_req: acc=%b re=%b addr=%h vld=%b, required 1 1 3800 0", spr_access_o, spr_re_o, spr_addr_o, smp_valid_o);
    end
    @(negedge clk);
    total++;
    if (smp_valid_o !== 1 || smp_data_o !== 32'h100) begin
      bad++; $display("FAIL latency_out: vld=%b data=%h, required 1 00000100", smp_valid_o, smp_data_o);
    end
    while (n < 8 && c < 60) begin
      if (smp_valid_o && smp_ready_i) begin
        total++;
        if (smp_data_o !== 32'h100 + n || smp_idx_o !== n[2:0] || smp_last_o !== (n == 7) || smp_seq_o !== 0) begin
          bad++; $display("FAIL beat%0d: data=%h idx=%0d last=%b seq=%0d, required %h %0d %b 0",
                          n, smp_data_o, smp_idx_o, smp_last_o, smp_seq_o, 32'h100 + n, n, n == 7);
        end
        n++;
      end
      @(negedge clk); c++;
    end
    total++;
    if (n != 8 || busy_o !== 0 || smp_seq_o !== 1 || reads - r0 != 8 || spr_we_o !== 0) begin
      bad++; $display("FAIL burst_end: beats=%0d busy=%b seq=%0d reads=%0d we=%b, required 8 0 1 8 0",
                      n, busy_o, smp_seq_o, reads - r0, spr_we_o);
    end
  endtask

  task automatic test_backpressure();
    int c = 0, r0;
    pulse_trigger();
    while (!(smp_valid_o && smp_idx_o == 3) && c < 40) begin @(negedge clk); c++; end
    smp_ready_i = 0;
    r0 = reads;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (smp_valid_o !== 1 || smp_data_o !== 32'h103 || smp_idx_o !== 3 || spr_access_o !== 0 || reads != r0) begin
        bad++; $display("FAIL stall%0d: vld=%b data=%h idx=%0d acc=%b extra_reads=%0d, required 1 103 3 0 0",
                        i, smp_valid_o, smp_data_o, smp_idx_o, spr_access_o, reads - r0);
      end
    end
    smp_ready_i = 1;
    wait_idle("bp_drain");
    total++;
    if (smp_seq_o !== 2 || drop_cnt_o !== 0) begin
      bad++; $display("FAIL bp_end: seq=%0d drop=%0d, required 2 0", smp_seq_o, drop_cnt_o);
    end
  endtask

  task automatic test_periodic();
    int rises[$];
    logic prev = 0;
    cfg_period_i = 20;
    for (int c = 0; c < 110; c++) begin
      @(negedge clk);
      if (busy_o && !prev) rises.push_back(c);
      prev = busy_o;
    end
    total++;
    if (rises.size() < 4) begin
      bad++; $display("FAIL periodic_count: bursts=%0d, required >=4", rises.size());
    end
    for (int i = 1; i < rises.size(); i++) begin
      total++;
      if (rises[i] - rises[i-1] != 20) begin
        bad++; $display("FAIL periodic_gap%0d: gap=%0d, required 20", i, rises[i] - rises[i-1]);
      end
    end
    total++;
    if (drop_cnt_o !== 0) begin bad++; $display("FAIL periodic_drop: drop=%0d, required 0", drop_cnt_o); end
    cfg_period_i = 0;
    wait_idle("periodic_idle");
  endtask

  task automatic test_drops();
    cfg_period_i = 4;
    // tick on the 4th edge starts a burst; ticks at +4,+8,+12,+16 land while busy
    repeat (20) @(negedge clk);
    total++;
    if (drop_cnt_o !== 4) begin bad++; $display("FAIL drops_first: drop=%0d, required 4", drop_cnt_o); end
    repeat (1600) @(negedge clk);
    total++;
    if (drop_cnt_o !== 8'd255) begin bad++; $display("FAIL drops_sat: drop=%0d, required 255", drop_cnt_o); end
    repeat (25) @(negedge clk);
    total++;
    if (drop_cnt_o !== 8'd255) begin bad++; $display("FAIL drops_hold: drop=%0d, required 255", drop_cnt_o); end
    cfg_period_i = 0;
    wait_idle("drops_idle");
  endtask

  task automatic test_timeout();
    int acc = 0, c = 0;
    logic [7:0] s0;
    s0 = smp_seq_o;
    ack_en = 0;
    pulse_trigger();
    while (spr_access_o && c < 40) begin acc++; @(negedge clk); c++; end
    total++;
    if (acc != 15 || spr_access_o !== 0 || busy_o !== 0 || timeout_err_o !== 1 || smp_seq_o !== s0 + 8'd1 || smp_valid_o !== 0) begin
      bad++; $display("FAIL timeout: req_cycles=%0d acc=%b busy=%b err=%b seq=%0d vld=%b, required 15 0 0 1 %0d 0",
                      acc, spr_access_o, busy_o, timeout_err_o, smp_seq_o, smp_valid_o, s0 + 8'd1);
    end
    ack_en = 1;
    repeat (3) @(negedge clk);
    total++;
    if (timeout_err_o !== 1) begin bad++; $display("FAIL err_sticky: err=%b, required 1", timeout_err_o); end
    err_clr_i = 1; @(negedge clk); err_clr_i = 0;
    total++;
    if (timeout_err_o !== 0) begin bad++; $display("FAIL err_clr: err=%b, required 0", timeout_err_o); end
  endtask

  task automatic test_reset_mid();
    int c = 0;
    pulse_trigger();
    while (!(smp_valid_o && smp_idx_o == 4) && c < 40) begin @(negedge clk); c++; end
    rst = 1; @(negedge clk); rst = 0;
    total++;
    if ({spr_access_o, smp_valid_o, smp_last_o, busy_o, timeout_err_o} !== 5'd0 || smp_data_o !== 0 ||
        smp_idx_o !== 0 || smp_seq_o !== 0 || drop_cnt_o !== 0 || spr_addr_o !== 16'h3800) begin
      bad++; $display("FAIL rst_mid: acc=%b vld=%b busy=%b data=%h idx=%0d seq=%0d drop=%0d addr=%h, required all 0 addr=3800",
                      spr_access_o, smp_valid_o, busy_o, smp_data_o, smp_idx_o, smp_seq_o, drop_cnt_o, spr_addr_o);
    end
    repeat (3) @(negedge clk);
    total++;
    if (smp_valid_o !== 0 || busy_o !== 0) begin bad++; $display("FAIL rst_quiet: vld=%b busy=%b, required 0 0", smp_valid_o, busy_o); end
    pulse_trigger();
    @(negedge clk);
    total++;
    if (smp_valid_o !== 1 || smp_idx_o !== 0 || smp_data_o !== 32'h100 || smp_seq_o !== 0) begin
      bad++; $display("FAIL rst_restart: vld=%b idx=%0d data=%h seq=%0d, required 1 0 100 0", smp_valid_o, smp_idx_o, smp_data_o, smp_seq_o);
    end
    wait_idle("rst_restart_idle");
  endtask

  initial begin
    test_reset();
    test_burst();
    test_backpressure();
    test_periodic();
    test_drops();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
